// File: rtl/pccard_ne2000_dma.sv
// rtl/pccard_ne2000_dma.sv - PC Card NE2000-style remote DMA engine with internal packet buffer
module pccard_ne2000_dma #(
    parameter int          BUF_AW   = 13,
    parameter logic [15:0] COR_ADDR = 16'h03F8,
    parameter logic [4:0]  IO_MASK  = 5'h1F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [25:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    input  logic        cc_reg,
    input  logic        cc_oe,
    input  logic        cc_we,
    input  logic        cc_iord,
    input  logic        cc_iowr,
    input  logic        cc_ce1,
    input  logic        cc_ce2,
    output logic        cc_ireq,
    output logic [7:0]  attr_addr,
    input  logic [7:0]  attr_q
);
    typedef enum logic [1:0] {IDLE, RD_FETCH, RD_READY, WR_READY} dma_state_t;

    localparam logic [15:0] ADDR_MASK = 16'((32'd1 << BUF_AW) - 1);
    localparam int          WORDS     = 2 ** (BUF_AW - 1);

    logic [7:0]  cor_q, cor_d, cr_q, cr_d, isr_q, isr_d, imr_q, imr_d;
    logic [7:0]  isr_set, isr_clr;
    logic [15:0] rsar_q, rsar_d, rbcr_q, rbcr_d, data_out_q, data_out_d;
    dma_state_t  state_q, state_d;
    logic        iord_q, iowr_q, we_q, ireq_q;
    logic [15:0] mem [WORDS];
    logic [15:0] rd_data_q, mem_wdata, io_rdata, attr_rdata, step;
    logic        mem_we_lo, mem_we_hi, dma_step, abort, soft_rst;
    logic        word_acc, io_acc, iord_edge, iowr_edge, attr_wr, attr_rd;
    logic [4:0]  offset;
    logic [1:0]  page;

    assign word_acc  = cc_ce1 & cc_ce2;
    assign io_acc    = cc_reg & cc_ce1 & cor_q[0];
    assign iord_edge = io_acc & cc_iord & ~iord_q;
    assign iowr_edge = io_acc & cc_iowr & ~iowr_q;
    assign attr_wr   = cc_reg & cc_ce1 & cc_we & ~we_q;
    assign attr_rd   = cc_reg & cc_ce1 & cc_oe;
    assign offset    = addr[4:0] & IO_MASK;
    assign page      = cr_q[7:6];
    assign attr_addr = addr[8:1];
    assign data_out  = data_out_q;
    assign cc_ireq   = ireq_q;

    always_comb begin
        attr_rdata = '0;
        if (addr == {10'd0, COR_ADDR})
            attr_rdata = {8'h00, cor_q};
        else if (addr[16:9] == 8'd0)
            attr_rdata = {8'h00, attr_q};
    end

    always_comb begin
        io_rdata = '0;
        case (offset)
            5'h00: io_rdata = {8'h00, cr_q[7:6], (state_q == IDLE) ? 3'b100 : cr_q[5:3], cr_q[2:0]};
            5'h07: if (page == 2'd0) io_rdata = {8'h00, isr_q};
            5'h08: if (page == 2'd0) io_rdata = {8'h00, rsar_q[7:0]};
            5'h09: if (page == 2'd0) io_rdata = {8'h00, rsar_q[15:8]};
            5'h0A: if (page == 2'd0) io_rdata = {8'h00, rbcr_q[7:0]};
            5'h0B: if (page == 2'd0) io_rdata = {8'h00, rbcr_q[15:8]};
            5'h0F: if (page == 2'd2) io_rdata = {8'h00, imr_q};
            5'h10: if (state_q == RD_READY)
                       io_rdata = word_acc ? rd_data_q
                                           : {8'h00, rsar_q[0] ? rd_data_q[15:8] : rd_data_q[7:0]};
            default: ;
        endcase
    end

    always_comb begin
        cor_d     = cor_q;
        cr_d      = cr_q;
        imr_d     = imr_q;
        rsar_d    = rsar_q;
        rbcr_d    = rbcr_q;
        state_d   = state_q;
        isr_set   = '0;
        isr_clr   = '0;
        mem_we_lo = 1'b0;
        mem_we_hi = 1'b0;
        mem_wdata = word_acc ? data_in : {data_in[7:0], data_in[7:0]};
        step      = word_acc ? 16'd2 : 16'd1;
        dma_step  = 1'b0;
        abort     = 1'b0;
        soft_rst  = cor_q[7];

        if (state_q == RD_FETCH) state_d = RD_READY;

        if (iowr_edge) begin
            case (offset)
                5'h00: begin
                    cr_d = data_in[7:0];
                    if (data_in[5]) begin
                        abort = 1'b1;
                    end else if (state_q == IDLE && (data_in[5:3] == 3'b001 || data_in[5:3] == 3'b010)) begin
                        if (rbcr_q == 16'd0)        isr_set[6] = 1'b1;
                        else if (data_in[3])        state_d = RD_FETCH;
                        else                        state_d = WR_READY;
                    end
                end
                5'h07: if (page == 2'd0) isr_clr = data_in[7:0];
                5'h08: if (page == 2'd0) rsar_d[7:0]  = data_in[7:0];
                5'h09: if (page == 2'd0) rsar_d[15:8] = data_in[7:0];
                5'h0A: if (page == 2'd0) rbcr_d[7:0]  = data_in[7:0];
                5'h0B: if (page == 2'd0) rbcr_d[15:8] = data_in[7:0];
                5'h0F: if (page == 2'd0) imr_d = data_in[7:0];
                5'h10: if (state_q == WR_READY) begin
                    dma_step  = 1'b1;
                    mem_we_lo = word_acc | ~rsar_q[0];
                    mem_we_hi = word_acc | rsar_q[0];
                end
                5'h1F: soft_rst = 1'b1;
                default: ;
            endcase
        end

        if (iord_edge) begin
            if (offset == 5'h10 && state_q == RD_READY) dma_step = 1'b1;
            if (offset == 5'h1F) soft_rst = 1'b1;
        end

        if (dma_step) begin
            rsar_d = (rsar_q + step) & ADDR_MASK;
            if (rbcr_q <= step) begin
                rbcr_d     = '0;
                state_d    = IDLE;
                isr_set[6] = 1'b1;
            end else begin
                rbcr_d = rbcr_q - step;
                if (state_q == RD_READY) state_d = RD_FETCH;
            end
        end

        if (abort) state_d = IDLE;

        // SRESET self-clears one cycle after the write that set it
        if (cor_q[7]) cor_d[7:6] = 2'b00;
        if (attr_wr && addr == {10'd0, COR_ADDR}) cor_d = data_in[7:0];

        if (soft_rst) begin
            state_d    = IDLE;
            cr_d       = 8'h21;
            imr_d      = 8'h00;
            isr_set[7] = 1'b1;
        end

        isr_d = (isr_q & ~isr_clr) | isr_set;

        if (attr_rd)        data_out_d = attr_rdata;
        else if (iord_edge) data_out_d = io_rdata;
        else if (cc_iord)   data_out_d = data_out_q;
        else                data_out_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cor_q      <= 8'h00;
            cr_q       <= 8'h21;
            isr_q      <= 8'h80;
            imr_q      <= 8'h00;
            rsar_q     <= '0;
            rbcr_q     <= '0;
            state_q    <= IDLE;
            ireq_q     <= 1'b0;
            data_out_q <= '0;
            iord_q     <= 1'b0;
            iowr_q     <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            cor_q      <= cor_d;
            cr_q       <= cr_d;
            isr_q      <= isr_d;
            imr_q      <= imr_d;
            rsar_q     <= rsar_d;
            rbcr_q     <= rbcr_d;
            state_q    <= state_d;
            ireq_q     <= cor_q[0] & |(isr_q[6:0] & imr_q[6:0]);
            data_out_q <= data_out_d;
            iord_q     <= cc_iord;
            iowr_q     <= cc_iowr;
            we_q       <= cc_we;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_lo) mem[rsar_q[BUF_AW-1:1]][7:0]  <= mem_wdata[7:0];
        if (mem_we_hi) mem[rsar_q[BUF_AW-1:1]][15:8] <= mem_wdata[15:8];
        if (state_q == RD_FETCH) rd_data_q <= mem[rsar_q[BUF_AW-1:1]];
    end
endmodule

// File: tb/tb_pccard_ne2000_dma.sv
// tb/tb_pccard_ne2000_dma.sv - self-checking bench for pccard_ne2000_dma
module tb_pccard_ne2000_dma;
    localparam int          BUF_AW    = 13;
    localparam int          BUF_BYTES = 1 << BUF_AW;
    localparam logic [25:0] COR_A     = 26'h3F8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [25:0] addr = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        cc_reg = 1'b0, cc_oe = 1'b0, cc_we = 1'b0, cc_iord = 1'b0, cc_iowr = 1'b0;
    logic        cc_ce1 = 1'b0, cc_ce2 = 1'b0;
    logic        cc_ireq;
    logic [7:0]  attr_addr;
    logic [7:0]  attr_q = 8'h00;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  ref_mem [BUF_BYTES];
    logic [15:0] rd;

    always #5 clk = ~clk;
    always @(posedge clk) attr_q <= attr_addr ^ 8'h5A;

    pccard_ne2000_dma #(.BUF_AW(BUF_AW), .COR_ADDR(16'h03F8), .IO_MASK(5'h1F)) dut (
        .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .data_out(data_out),
        .cc_reg(cc_reg), .cc_oe(cc_oe), .cc_we(cc_we), .cc_iord(cc_iord), .cc_iowr(cc_iowr),
        .cc_ce1(cc_ce1), .cc_ce2(cc_ce2), .cc_ireq(cc_ireq), .attr_addr(attr_addr), .attr_q(attr_q)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        cc_reg = 1'b0; cc_oe = 1'b0; cc_we = 1'b0; cc_iord = 1'b0; cc_iowr = 1'b0;
        cc_ce1 = 1'b0; cc_ce2 = 1'b0;
    endtask

    task automatic io_wr(input logic [4:0] off, input logic [15:0] d, input bit word);
        addr = {21'd0, off}; data_in = d; cc_reg = 1'b1; cc_ce1 = 1'b1; cc_ce2 = word; cc_iowr = 1'b1;
        @(negedge clk);
        bus_idle();
        @(negedge clk);
    endtask

    task automatic io_rd(input logic [4:0] off, input bit word, output logic [15:0] d);
        addr = {21'd0, off}; cc_reg = 1'b1; cc_ce1 = 1'b1; cc_ce2 = word; cc_iord = 1'b1;
        @(negedge clk);
        d = data_out;
        bus_idle();
        @(negedge clk);
    endtask

    task automatic attr_wr(input logic [25:0] a, input logic [7:0] d);
        addr = a; data_in = {8'h00, d}; cc_reg = 1'b1; cc_ce1 = 1'b1; cc_we = 1'b1;
        @(negedge clk);
        bus_idle();
        @(negedge clk);
    endtask

    task automatic attr_rd(input logic [25:0] a, output logic [15:0] d);
        addr = a; cc_reg = 1'b1; cc_ce1 = 1'b1; cc_oe = 1'b1;
        repeat (2) @(negedge clk);
        d = data_out;
        bus_idle();
        @(negedge clk);
    endtask

    task automatic reg_chk(input string tag, input logic [4:0] off, input logic [7:0] exp);
        logic [15:0] v;
        io_rd(off, 1'b0, v);
        check_eq(tag, {16'd0, v}, {24'd0, exp});
    endtask

    task automatic imr_chk(input string tag, input logic [7:0] exp);
        io_wr(5'h00, 16'h00A1, 1'b0);
        reg_chk(tag, 5'h0F, exp);
        io_wr(5'h00, 16'h0021, 1'b0);
    endtask

    task automatic set_dma(input logic [15:0] sa, input logic [15:0] cnt);
        io_wr(5'h08, {8'h00, sa[7:0]}, 1'b0);
        io_wr(5'h09, {8'h00, sa[15:8]}, 1'b0);
        io_wr(5'h0A, {8'h00, cnt[7:0]}, 1'b0);
        io_wr(5'h0B, {8'h00, cnt[15:8]}, 1'b0);
    endtask

    task automatic rsar_chk(input string tag, input int exp);
        logic [15:0] lo, hi;
        io_rd(5'h08, 1'b0, lo);
        io_rd(5'h09, 1'b0, hi);
        check_eq(tag, {16'd0, hi[7:0], lo[7:0]}, 32'(exp));
    endtask

    task automatic rand_dma(input int iter);
        int start, cnt, p, c;
        bit wd;
        logic [15:0] d, v;
        start = $urandom_range(0, BUF_BYTES - 1);
        cnt   = $urandom_range(1, 12);
        io_wr(5'h07, 16'h00FF, 1'b0);
        set_dma(16'(start), 16'(cnt));
        io_wr(5'h00, 16'h0012, 1'b0);
        p = start; c = cnt;
        while (c > 0) begin
            wd = (c >= 2) && (p % 2 == 0) && ($urandom_range(0, 1) == 1);
            d  = 16'($urandom);
            io_wr(5'h10, d, wd);
            ref_mem[p] = d[7:0];
            if (wd) begin
                ref_mem[p + 1] = d[15:8];
                p = (p + 2) % BUF_BYTES; c -= 2;
            end else begin
                p = (p + 1) % BUF_BYTES; c -= 1;
            end
        end
        reg_chk($sformatf("rnd%0d_wr_isr", iter), 5'h07, 8'h40);
        rsar_chk($sformatf("rnd%0d_wr_rsar", iter), p);
        reg_chk($sformatf("rnd%0d_wr_cr", iter), 5'h00, 8'h22);
        io_wr(5'h07, 16'h00FF, 1'b0);
        set_dma(16'(start), 16'(cnt));
        io_wr(5'h00, 16'h000A, 1'b0);
        p = start; c = cnt;
        while (c > 0) begin
            wd = (c >= 2) && (p % 2 == 0) && ($urandom_range(0, 1) == 1);
            io_rd(5'h10, wd, v);
            if (wd) begin
                check_eq($sformatf("rnd%0d_rdw@%0h", iter, p), {16'd0, v}, {16'd0, ref_mem[p + 1], ref_mem[p]});
                p = (p + 2) % BUF_BYTES; c -= 2;
            end else begin
                check_eq($sformatf("rnd%0d_rdb@%0h", iter, p), {16'd0, v}, {24'd0, ref_mem[p]});
                p = (p + 1) % BUF_BYTES; c -= 1;
            end
        end
        reg_chk($sformatf("rnd%0d_rd_isr", iter), 5'h07, 8'h40);
        rsar_chk($sformatf("rnd%0d_rd_rsar", iter), p);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] w1, w2;
        repeat (3) @(negedge clk);
        check_eq("rst_data_out", {16'd0, data_out}, 32'd0);
        check_eq("rst_ireq", {31'd0, cc_ireq}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        attr_rd(COR_A, rd);            check_eq("cor_rst", {16'd0, rd}, 32'h0);
        io_rd(5'h00, 1'b0, rd);        check_eq("io_disabled_cr", {16'd0, rd}, 32'h0);
        attr_wr(COR_A, 8'h01);
        attr_rd(COR_A, rd);            check_eq("cor_rb", {16'd0, rd}, 32'h0001);
        attr_rd(26'h10, rd);           check_eq("cis_rd", {16'd0, rd}, {24'd0, 8'h08 ^ 8'h5A});
        attr_rd(26'h400, rd);          check_eq("attr_unmapped", {16'd0, rd}, 32'h0);
        reg_chk("cr_rst", 5'h00, 8'h21);
        reg_chk("isr_rst", 5'h07, 8'h80);
        rsar_chk("rsar_rst", 0);
        reg_chk("rbcr_rst", 5'h0A, 8'h00);
        imr_chk("imr_rst", 8'h00);
        reg_chk("unimpl", 5'h03, 8'h00);

        io_wr(5'h07, 16'h00FF, 1'b0);
        set_dma(16'h0100, 16'd4);
        io_wr(5'h00, 16'h0012, 1'b0);
        reg_chk("cr_active", 5'h00, 8'h12);
        io_wr(5'h10, 16'hA1B2, 1'b1);
        io_wr(5'h10, 16'hC3D4, 1'b1);
        reg_chk("wr_isr", 5'h07, 8'h40);
        rsar_chk("wr_rsar", 16'h0104);
        reg_chk("cr_idle", 5'h00, 8'h22);
        io_wr(5'h07, 16'h00FF, 1'b0);
        set_dma(16'h0100, 16'd4);
        io_wr(5'h00, 16'h000A, 1'b0);
        io_rd(5'h10, 1'b1, rd);        check_eq("rd_w0", {16'd0, rd}, 32'hA1B2);
        io_rd(5'h10, 1'b1, rd);        check_eq("rd_w1", {16'd0, rd}, 32'hC3D4);
        reg_chk("rd_isr", 5'h07, 8'h40);

        w1 = 16'($urandom); w2 = 16'($urandom);
        set_dma(16'(BUF_BYTES - 2), 16'd4);
        io_wr(5'h00, 16'h0012, 1'b0);
        io_wr(5'h10, w1, 1'b1);
        io_wr(5'h10, w2, 1'b1);
        rsar_chk("wrap_rsar", 2);
        set_dma(16'h0000, 16'd2);
        io_wr(5'h00, 16'h000A, 1'b0);
        io_rd(5'h10, 1'b1, rd);        check_eq("wrap_w0", {16'd0, rd}, {16'd0, w2});
        set_dma(16'(BUF_BYTES - 2), 16'd2);
        io_wr(5'h00, 16'h000A, 1'b0);
        io_rd(5'h10, 1'b1, rd);        check_eq("wrap_top", {16'd0, rd}, {16'd0, w1});

        io_wr(5'h07, 16'h00FF, 1'b0);
        set_dma(16'h0700, 16'd0);
        io_wr(5'h00, 16'h000A, 1'b0);
        reg_chk("zero_cnt_isr", 5'h07, 8'h40);
        reg_chk("zero_cnt_cr", 5'h00, 8'h22);

        io_wr(5'h07, 16'h00FF, 1'b0);
        io_wr(5'h0F, 16'h0040, 1'b0);
        imr_chk("imr_rb", 8'h40);
        set_dma(16'h0400, 16'd2);
        io_wr(5'h00, 16'h0012, 1'b0);
        addr = 26'h10; data_in = 16'hBEEF; cc_reg = 1'b1; cc_ce1 = 1'b1; cc_ce2 = 1'b1; cc_iowr = 1'b1;
        @(negedge clk);
        check_eq("ireq_pre", {31'd0, cc_ireq}, 32'd0);
        bus_idle();
        @(negedge clk);
        check_eq("ireq_set", {31'd0, cc_ireq}, 32'd1);
        addr = 26'h07; data_in = 16'h0040; cc_reg = 1'b1; cc_ce1 = 1'b1; cc_iowr = 1'b1;
        @(negedge clk);
        check_eq("ireq_hold", {31'd0, cc_ireq}, 32'd1);
        bus_idle();
        @(negedge clk);
        check_eq("ireq_clr", {31'd0, cc_ireq}, 32'd0);

        set_dma(16'h0200, 16'd10);
        io_wr(5'h00, 16'h000A, 1'b0);
        addr = 26'h10; cc_reg = 1'b1; cc_ce1 = 1'b1; cc_ce2 = 1'b1; cc_iord = 1'b1;
        repeat (10) @(negedge clk);
        bus_idle();
        @(negedge clk);
        rsar_chk("hold_rsar", 16'h0202);
        reg_chk("hold_rbcr", 5'h0A, 8'd8);
        io_rd(5'h10, 1'b0, rd);
        rsar_chk("byte_rsar", 16'h0203);
        reg_chk("byte_rbcr", 5'h0A, 8'd7);
        io_wr(5'h10, 16'h1234, 1'b1);
        rsar_chk("wr_in_rd_rsar", 16'h0203);
        io_wr(5'h00, 16'h0022, 1'b0);
        reg_chk("abort_cr", 5'h00, 8'h22);
        reg_chk("abort_isr", 5'h07, 8'h00);
        io_rd(5'h10, 1'b1, rd);        check_eq("idle_data_rd", {16'd0, rd}, 32'h0);

        io_rd(5'h1F, 1'b0, rd);
        reg_chk("rstport_isr", 5'h07, 8'h80);
        reg_chk("rstport_cr", 5'h00, 8'h21);
        imr_chk("rstport_imr", 8'h00);

        io_wr(5'h07, 16'h00FF, 1'b0);
        io_wr(5'h0F, 16'h0040, 1'b0);
        set_dma(16'h0500, 16'd4);
        io_wr(5'h00, 16'h0012, 1'b0);
        attr_wr(COR_A, 8'h81);
        attr_rd(COR_A, rd);            check_eq("sreset_cor", {16'd0, rd}, 32'h0001);
        reg_chk("sreset_cr", 5'h00, 8'h21);
        reg_chk("sreset_isr", 5'h07, 8'h80);
        imr_chk("sreset_imr", 8'h00);

        for (int i = 0; i < 8; i++) rand_dma(i);

        io_wr(5'h0F, 16'h0040, 1'b0);
        set_dma(16'h0300, 16'd8);
        io_wr(5'h00, 16'h0012, 1'b0);
        io_wr(5'h10, 16'h5555, 1'b1);
        #3 reset = 1'b0;
        #2;
        check_eq("midrst_data_out", {16'd0, data_out}, 32'd0);
        check_eq("midrst_ireq", {31'd0, cc_ireq}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        attr_rd(COR_A, rd);            check_eq("midrst_cor", {16'd0, rd}, 32'h0);
        attr_wr(COR_A, 8'h01);
        reg_chk("midrst_cr", 5'h00, 8'h21);
        reg_chk("midrst_isr", 5'h07, 8'h80);
        rsar_chk("midrst_rsar", 0);
        reg_chk("midrst_rbcr0", 5'h0A, 8'h00);
        reg_chk("midrst_rbcr1", 5'h0B, 8'h00);
        imr_chk("midrst_imr", 8'h00);
        io_wr(5'h10, 16'h7777, 1'b1);
        rsar_chk("midrst_idle_wr", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
